// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and round functions for the iterative core.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [0:7]  state_t;   // index 0 = a/H0 occupies the MSBs
  typedef word_t [0:15] window_t;  // index 0 = W0 occupies the MSBs

  typedef enum logic [1:0] {IDLE, RUN, FIN, HOLD} fsm_t;

  localparam state_t IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ep0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t ep1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t sig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round plus the matching message-schedule step.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] st_in,
  input  logic [511:0] win_in,
  input  logic [31:0]  k,
  output logic [255:0] st_out,
  output logic [511:0] win_out
);

  state_t  s;
  window_t w;
  word_t   t1, t2, w_new;

  assign s = st_in;
  assign w = win_in;

  assign t1    = s[7] + ep1(s[4]) + ch(s[4], s[5], s[6]) + k + w[0];
  assign t2    = ep0(s[0]) + maj(s[0], s[1], s[2]);
  assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

  assign st_out  = {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  assign win_out = {w[1:15], w_new};

endmodule

// File: rtl/sha256_iter_core.sv
// Handshaked iterative SHA-256 compression engine, RPC rounds per clock.
// Optional double-hash pass enabled by defining SHA256_ITER_DOUBLE_EN.
module sha256_iter_core
  import sha256_pkg::*;
#(
  parameter int RPC     = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef SHA256_ITER_DOUBLE_EN
  input  logic         in_double,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_use_iv,
  input  logic [255:0] in_state,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

  if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : g_bad_rpc
    $error("sha256_iter_core: RPC must be 1, 2, 4, 8 or 16");
  end

  localparam logic [5:0] RPC6 = 6'(RPC);

  fsm_t       state_reg, state_next;
  logic [5:0] cnt_reg, cnt_next;
  state_t     h_reg, work_reg, sum_state;
  window_t    win_reg;
  logic       dbl_pend;

  state_t  st_chain  [0:RPC];
  window_t win_chain [0:RPC];

  assign st_chain[0]  = work_reg;
  assign win_chain[0] = win_reg;
  assign cnt_next     = cnt_reg + RPC6;

  for (genvar gi = 0; gi < RPC; gi++) begin : g_round
    sha256_round u_round (
      .st_in  (st_chain[gi]),
      .win_in (win_chain[gi]),
      .k      (K[cnt_reg + 6'(gi)]),
      .st_out (st_chain[gi+1]),
      .win_out(win_chain[gi+1])
    );
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_sum
    assign sum_state[gi] = h_reg[gi] + work_reg[gi];
  end

`ifdef SHA256_ITER_DOUBLE_EN
  logic dbl_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           dbl_reg <= 1'b0;
    else if (state_reg == IDLE && in_valid) dbl_reg <= in_double;
    else if (state_reg == FIN)            dbl_reg <= 1'b0;
  end
  assign dbl_pend = dbl_reg;
`else
  assign dbl_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN:  if (cnt_next == 6'd0) state_next = FIN;
      FIN:  state_next = dbl_pend ? RUN : HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // cnt_reg is already back at zero when FIN starts a second pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      h_reg    <= '0;
      work_reg <= '0;
      win_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          win_reg  <= in_block;
          h_reg    <= in_use_iv ? IV : state_t'(in_state);
          work_reg <= in_use_iv ? IV : state_t'(in_state);
          cnt_reg  <= '0;
        end
        RUN: begin
          work_reg <= st_chain[RPC];
          win_reg  <= win_chain[RPC];
          cnt_reg  <= cnt_next;
        end
        FIN: if (dbl_pend) begin
          win_reg  <= {sum_state, 32'h80000000, 192'h0, 32'h00000100};
          h_reg    <= IV;
          work_reg <= IV;
        end else begin
          h_reg <= sum_state;
          if (!OUT_REG) work_reg <= sum_state;
        end
        default: ;
      endcase
    end
  end

  if (OUT_REG) begin : g_out_reg
    state_t digest_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            digest_reg <= '0;
      else if (state_reg == FIN && !dbl_pend) digest_reg <= sum_state;
    end
    assign out_digest = digest_reg;
  end else begin : g_out_comb
    assign out_digest = work_reg;
  end

endmodule
